mul_controller: RTL and testbench
=================================

Name: mul_controller

Overview:
Multi-cycle sequencer wrapping the team's combinational 32x32 signed radix-4 Booth multiplier.
- Latches operands on a start request and holds them stable on the multiplier inputs for a fixed settle window (multicycle path).
- Captures the 64-bit product into the HI/LO register pair and signals completion to the CPU control unit.
- Also provides CPU-side direct HI/LO writes (mthi/mtlo) while idle.

Parameters:
LATENCY, 4, cycles from start acceptance to product capture; legal range 1..15.

Ports:
clock  input  1  system clock, rising edge
clear  input  1  synchronous active-high reset
start  input  1  request a multiply of op_a*op_b; sampled on clock edge
op_a  input  32  multiplicand, signed two's complement
op_b  input  32  multiplier, signed two's complement
hi_wr  input  1  direct write of hi_in into HI
lo_wr  input  1  direct write of lo_in into LO
hi_in  input  32  data for direct HI write
lo_in  input  32  data for direct LO write
mul_a  output  32  operand A driven to the multiplier instance
mul_b  output  32  operand B driven to the multiplier instance
mul_result  input  64  signed product returned by the multiplier instance
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
start_err  output  1  one-cycle pulse: start received while busy
hi_out  output  32  HI register (product bits 63:32)
lo_out  output  32  LO register (product bits 31:0)

Behaviour:
- Single clock. clear is synchronous and active-high; it overrides everything.
- On clear: state=IDLE, counter=0, mul_a=mul_b=0, hi_out=lo_out=0, busy=0, done=0, start_err=0.
- clear during WAIT aborts the operation: no capture, no done pulse.
- States: IDLE, WAIT, DONE. 4-bit down-counter cnt.

IDLE:
- start=1: mul_a<=op_a, mul_b<=op_b, cnt<=LATENCY-1, go to WAIT.
- Otherwise stay in IDLE.

WAIT:
- busy=1. Operand registers are held unchanged.
- cnt!=0: cnt<=cnt-1.
- cnt==0: hi_out<=mul_result[63:32], lo_out<=mul_result[31:0], go to DONE.

DONE:
- done=1, busy=0 for exactly one cycle.
- start=1: accepted exactly as in IDLE (back-to-back issue), go to WAIT.
- Otherwise go to IDLE.

Timing:
- With start accepted at edge N, HI/LO update at edge N+LATENCY.
- done is high in the cycle following that edge.
- LATENCY=1: capture occurs at the first edge after acceptance.

Start while busy:
- start=1 in WAIT is ignored: operands and counter unchanged.
- start_err pulses high for the following cycle.

Direct HI/LO writes:
- hi_wr/lo_wr take effect at the edge only when busy=0 (IDLE or DONE); both may be asserted together.
- Ignored in WAIT.
- A write in DONE updates the register normally.
- If start and hi_wr/lo_wr coincide in IDLE/DONE, both take effect.

Outputs:
- hi_out/lo_out hold their value until the next capture, direct write, or clear.
- All outputs are registered except busy/done, which decode from state only.
- No arithmetic is performed in this block; the product is captured verbatim from the 64-bit input.

Test Plan:
- LATENCY=4, op_a=3, op_b=5, start pulsed at edge 0 -> busy high cycles 1-4; done high cycle 5 only; hi_out=0x00000000, lo_out=0x0000000F.
- op_a=0xFFFFFFFF (-1), op_b=1 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFF; op_a=op_b=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000.
- Start 7*6, then start 2*9 with op_a changed mid-WAIT -> start_err pulses once; mul_a stays 7; final lo_out=42.
- Start held high continuously with operands 4*4 then 5*5 -> second op accepted in the DONE cycle; lo_out=16 then 25; done pulses twice, separated by LATENCY+1 cycles.
- clear asserted at cycle 2 of WAIT -> next cycle state IDLE, busy=0, hi_out=lo_out=0, no done pulse ever.
- hi_wr=1, hi_in=0xDEADBEEF during WAIT -> HI unchanged; same write in IDLE -> hi_out=0xDEADBEEF next cycle. LATENCY=1 run of 3*5 -> done one cycle after the capture edge, lo_out=15.

Source files
------------

// File: rtl/mul_controller.sv
// Multi-cycle sequencer around the external 32x32 signed Booth multiplier.
// Holds operands for LATENCY cycles, then captures the product into HI/LO.
module mul_controller #(
    parameter int unsigned LATENCY = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        busy,
    output logic        done,
    output logic        start_err,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (hi_wr) hi_d = hi_in;
                if (lo_wr) lo_d = lo_in;
                if (start) begin
                    mul_a_d = op_a;
                    mul_b_d = op_b;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // Operands stay frozen for the multicycle path.
                err_d = start;
                if (cnt_q == 4'd0) begin
                    hi_d    = mul_result[63:32];
                    lo_d    = mul_result[31:0];
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            mul_a_q <= 32'd0;
            mul_b_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == S_WAIT);
    assign done      = (state_q == S_DONE);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign start_err = err_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule

// File: tb/tb_mul_controller.sv
// Bench for mul_controller: LATENCY=4 and LATENCY=1 instances share stimulus
// and are compared each cycle against a countdown-style reference model.
module tb_mul_controller;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, hi_in = '0, lo_in = '0;
    logic        hi_wr = 1'b0, lo_wr = 1'b0;

    logic [31:0] mul_a0, mul_b0, hi0, lo0;
    logic [31:0] mul_a1, mul_b1, hi1, lo1;
    logic [63:0] res0, res1;
    logic        busy0, done0, err0, busy1, done1, err1;

    int ncmp = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    function automatic logic [63:0] smul(logic [31:0] a, logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    assign res0 = smul(mul_a0, mul_b0);
    assign res1 = smul(mul_a1, mul_b1);

    mul_controller #(.LATENCY(4)) dut0 (
        .clock(clock), .clear(clear), .start(start),
        .op_a(op_a), .op_b(op_b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .hi_in(hi_in), .lo_in(lo_in),
        .mul_a(mul_a0), .mul_b(mul_b0), .mul_result(res0),
        .busy(busy0), .done(done0), .start_err(err0),
        .hi_out(hi0), .lo_out(lo0)
    );

    mul_controller #(.LATENCY(1)) dut1 (
        .clock(clock), .clear(clear), .start(start),
        .op_a(op_a), .op_b(op_b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .hi_in(hi_in), .lo_in(lo_in),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_result(res1),
        .busy(busy1), .done(done1), .start_err(err1),
        .hi_out(hi1), .lo_out(lo1)
    );

    // Reference: rem = cycles left until the product lands (0 = not busy).
    typedef struct {
        int          rem;
        logic        done;
        logic        err;
        logic [31:0] ma, mb, hi, lo;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t step(mdl_t m, int lat);
        mdl_t n;
        logic [63:0] p;
        n = m;
        n.done = 1'b0;
        n.err = 1'b0;
        if (clear) begin
            n.rem = 0;
            n.ma = '0; n.mb = '0; n.hi = '0; n.lo = '0;
        end else if (m.rem > 0) begin
            n.err = start;
            n.rem = m.rem - 1;
            if (n.rem == 0) begin
                p = smul(m.ma, m.mb);
                n.hi = p[63:32];
                n.lo = p[31:0];
                n.done = 1'b1;
            end
        end else begin
            if (hi_wr) n.hi = hi_in;
            if (lo_wr) n.lo = lo_in;
            if (start) begin
                n.ma = op_a;
                n.mb = op_b;
                n.rem = lat;
            end
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("d0_busy", 64'(busy0), 64'(m0.rem > 0));
        chk("d0_done", 64'(done0), 64'(m0.done));
        chk("d0_err", 64'(err0), 64'(m0.err));
        chk("d0_mula", 64'(mul_a0), 64'(m0.ma));
        chk("d0_mulb", 64'(mul_b0), 64'(m0.mb));
        chk("d0_hi", 64'(hi0), 64'(m0.hi));
        chk("d0_lo", 64'(lo0), 64'(m0.lo));
        chk("d1_busy", 64'(busy1), 64'(m1.rem > 0));
        chk("d1_done", 64'(done1), 64'(m1.done));
        chk("d1_err", 64'(err1), 64'(m1.err));
        chk("d1_mula", 64'(mul_a1), 64'(m1.ma));
        chk("d1_hi", 64'(hi1), 64'(m1.hi));
        chk("d1_lo", 64'(lo1), 64'(m1.lo));
    endtask

    task automatic cyc();
        @(posedge clock);
        m0 = step(m0, 4);
        m1 = step(m1, 1);
        #1;
        check_all();
    endtask

    task automatic drain(int n);
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    typedef struct {
        logic [31:0] a, b, hi, lo;
    } vec_t;

    vec_t tbl[6];
    int   lat, t1, t2, nd;
    logic [31:0] lo_a, lo_b;

    initial begin
        tbl[0] = '{32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F};
        tbl[1] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[2] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        tbl[3] = '{32'd7, 32'd6, 32'h0, 32'd42};
        tbl[4] = '{32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
        tbl[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1};

        m0 = '{0, 1'b0, 1'b0, '0, '0, '0, '0};
        m1 = m0;
        cyc();
        cyc();
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_hi", 64'(hi0), 64'd0);
        chk("rst_lo", 64'(lo0), 64'd0);
        chk("rst_mula", 64'(mul_a0), 64'd0);
        clear = 1'b0;
        cyc();

        // Product table with end-to-end latency measurement.
        foreach (tbl[v]) begin
            op_a = tbl[v].a; op_b = tbl[v].b; start = 1'b1;
            cyc();
            start = 1'b0;
            chk("tbl_busy", 64'(busy0), 64'd1);
            lat = 0;
            for (int k = 0; k < 20 && !done0; k++) begin
                cyc();
                lat++;
            end
            chk("tbl_lat", 64'(lat), 64'd4);
            chk("tbl_hi", 64'(hi0), 64'(tbl[v].hi));
            chk("tbl_lo", 64'(lo0), 64'(tbl[v].lo));
            cyc();
            chk("tbl_done_1cyc", 64'(done0), 64'd0);
        end

        // Start while busy is flagged and ignored.
        op_a = 32'd7; op_b = 32'd6; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        op_a = 32'd2; op_b = 32'd9; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("err_pulse", 64'(err0), 64'd1);
        chk("err_mula", 64'(mul_a0), 64'd7);
        cyc();
        chk("err_clr", 64'(err0), 64'd0);
        for (int k = 0; k < 10 && !done0; k++) cyc();
        chk("err_lo", 64'(lo0), 64'd42);
        drain(3);

        // Start held high: back-to-back issue from DONE.
        op_a = 32'd4; op_b = 32'd4; start = 1'b1;
        cyc();
        op_a = 32'd5; op_b = 32'd5;
        nd = 0; t1 = 0; t2 = 0; lo_a = '0; lo_b = '0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (done0) begin
                nd++;
                if (nd == 1) begin t1 = k; lo_a = lo0; end
                if (nd == 2) begin t2 = k; lo_b = lo0; end
            end
        end
        chk("b2b_first", 64'(lo_a), 64'd16);
        chk("b2b_second", 64'(lo_b), 64'd25);
        chk("b2b_gap", 64'(t2 - t1), 64'd5);
        drain(8);

        // Clear mid-WAIT aborts with no done pulse.
        op_a = 32'd11; op_b = 32'd13; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_busy", 64'(busy0), 64'd0);
        chk("clr_hi", 64'(hi0), 64'd0);
        chk("clr_lo", 64'(lo0), 64'd0);
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (done0) nd++;
        end
        chk("clr_nodone", 64'(nd), 64'd0);

        // Direct HI write blocked in WAIT, taken in IDLE.
        op_a = 32'd2; op_b = 32'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        hi_wr = 1'b1; hi_in = 32'hDEAD_BEEF;
        cyc();
        hi_wr = 1'b0;
        chk("wr_wait_hi", 64'(hi0), 64'd0);
        drain(6);
        hi_wr = 1'b1;
        cyc();
        hi_wr = 1'b0;
        chk("wr_idle_hi", 64'(hi0), 64'hDEAD_BEEF);
        drain(2);

        // LATENCY=1 instance.
        op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("l1_busy", 64'(busy1), 64'd1);
        chk("l1_nodone", 64'(done1), 64'd0);
        cyc();
        chk("l1_done", 64'(done1), 64'd1);
        chk("l1_lo", 64'(lo1), 64'd15);
        drain(6);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 9) < 3);
            op_a  = $urandom();
            op_b  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
            hi_wr = ($urandom_range(0, 9) == 0);
            lo_wr = ($urandom_range(0, 9) == 0);
            hi_in = $urandom();
            lo_in = $urandom();
            clear = ($urandom_range(0, 49) == 0);
            cyc();
        end
        clear = 1'b0;
        drain(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
